uart_tx_feeder: RTL and testbench

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_tx_feeder.sv | 110 +++++++++++
 tb/tb_uart_tx_feeder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// FIFO-buffered word feeder for a UART transmitter: queues 32-bit words and issues them one at a time.
// Optional `UART_TX_FEEDER_DROP_CNT_EN adds a saturating drop_count of pushes refused while full.
module uart_tx_feeder #(
   parameter int DEPTH       = 4,
   parameter int ACK_TIMEOUT = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_valid,
   input  logic [31:0]              push_data,
   output logic                     push_ready,
   input  logic                     tx_busy,
   output logic                     tx_write_en,
   output logic [31:0]              tx_data_out,
   output logic [$clog2(DEPTH):0]   fifo_count,
`ifdef UART_TX_FEEDER_DROP_CNT_EN
   output logic [7:0]               drop_count,
`endif
   output logic                     fifo_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);
   localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, ACK_WAIT, DRAIN} state_t;

   state_t        state;
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [TW-1:0] timer;
   logic          push_acc;
   logic          pop;

   // Push acceptance looks at the pre-pop count, so a full FIFO refuses even on a pop edge.
   assign push_ready = (fifo_count != FULL);
   assign fifo_empty = (fifo_count == '0);
   assign push_acc   = push_valid && push_ready;
   assign pop        = (state == IDLE) && !fifo_empty && !tx_busy;

   always_ff @(posedge clk) begin
      if (push_acc)
         mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push_acc)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push_acc, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: ;
         endcase
      end
   end

   // A word whose transmitter never acknowledges is treated as sent once the timer expires.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         tx_write_en <= 1'b0;
         tx_data_out <= '0;
         timer       <= '0;
      end else begin
         tx_write_en <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  tx_data_out <= mem[rd_ptr];
                  tx_write_en <= 1'b1;
                  timer       <= '0;
                  state       <= ACK_WAIT;
               end
            end
            ACK_WAIT: begin
               if (tx_busy)
                  state <= DRAIN;
               else if (timer == TO_LAST)
                  state <= IDLE;
               else
                  timer <= timer + 1'b1;
            end
            DRAIN: begin
               if (!tx_busy)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef UART_TX_FEEDER_DROP_CNT_EN
   always_ff @(posedge clk) begin
      if (reset)
         drop_count <= '0;
      else if (push_valid && !push_ready && drop_count != 8'hFF)
         drop_count <= drop_count + 1'b1;
   end
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder (DEPTH=4, ACK_TIMEOUT=4) with a simple busy-responder model.
module tb_uart_tx_feeder;

   logic        clk = 1'b0;
   logic        reset;
   logic        push_valid;
   logic [31:0] push_data;
   logic        push_ready;
   logic        tx_busy;
   logic        tx_write_en;
   logic [31:0] tx_data_out;
   logic [2:0]  fifo_count;
   logic        fifo_empty;
`ifdef UART_TX_FEEDER_DROP_CNT_EN
   logic [7:0]  drop_count;
`endif

   logic        man_busy   = 1'b0;
   logic        model_en   = 1'b0;
   logic        model_busy = 1'b0;
   int          busy_viol  = 0;
   int          checks     = 0;
   int          failures   = 0;
   logic [31:0] got[$];

   always #5 clk = ~clk;

   assign tx_busy = model_en ? model_busy : man_busy;

   uart_tx_feeder #(.DEPTH(4), .ACK_TIMEOUT(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .push_valid  (push_valid),
      .push_data   (push_data),
      .push_ready  (push_ready),
      .tx_busy     (tx_busy),
      .tx_write_en (tx_write_en),
      .tx_data_out (tx_data_out),
      .fifo_count  (fifo_count),
`ifdef UART_TX_FEEDER_DROP_CNT_EN
      .drop_count  (drop_count),
`endif
      .fifo_empty  (fifo_empty)
   );

   // Transmitter model: goes busy for 10 cycles after each strobe; a strobe while busy is a violation.
   always begin
      @(posedge clk); #1;
      if (model_en && tx_write_en) begin
         model_busy = 1'b1;
         repeat (10) begin
            @(posedge clk); #1;
            if (tx_write_en) busy_viol++;
         end
         model_busy = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic push(input logic [31:0] d);
      push_valid = 1'b1;
      push_data  = d;
      tick();
      push_valid = 1'b0;
   endtask

   task automatic collect(input int n, input int budget);
      got.delete();
      for (int c = 0; c < budget && got.size() < n; c++) begin
         tick();
         if (tx_write_en) got.push_back(tx_data_out);
      end
      check("collect_count", 32'(got.size()), 32'(n));
   endtask

   function automatic logic [31:0] got_at(input int i);
      return (i < got.size()) ? got[i] : 32'hxxxxxxxx;
   endfunction

   initial begin
      reset = 1'b1; push_valid = 1'b0; push_data = '0;
      tick(); tick();
      check("rst_count", 32'(fifo_count), 0);
      check("rst_empty", 32'(fifo_empty), 1);
      check("rst_ready", 32'(push_ready), 1);
      check("rst_wen",   32'(tx_write_en), 0);
      check("rst_data",  tx_data_out, 0);
`ifdef UART_TX_FEEDER_DROP_CNT_EN
      check("rst_drop",  32'(drop_count), 0);
`endif
      reset = 1'b0;

      // Single word into an empty FIFO: strobe one cycle after the push edge.
      push(32'hDEADBEEF);
      check("lat_count", 32'(fifo_count), 1);
      check("lat_wen0",  32'(tx_write_en), 0);
      tick();
      check("lat_wen1",  32'(tx_write_en), 1);
      check("lat_data",  tx_data_out, 32'hDEADBEEF);
      check("lat_count0", 32'(fifo_count), 0);
      tick();
      check("lat_wen_off", 32'(tx_write_en), 0);
      check("lat_hold",  tx_data_out, 32'hDEADBEEF);
      repeat (5) tick();

      // Five pushes while busy: four accepted, fifth dropped.
      man_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         push(32'hA000_0000 + 32'(i));
         if (i == 3) begin
            check("full_count4", 32'(fifo_count), 4);
            check("full_ready",  32'(push_ready), 0);
         end
      end
      check("full_count5", 32'(fifo_count), 4);
      check("full_empty",  32'(fifo_empty), 0);
`ifdef UART_TX_FEEDER_DROP_CNT_EN
      check("drop_one",    32'(drop_count), 1);
`endif

      // No acknowledgement: the next issue comes five edges after the previous one.
      man_busy = 1'b0;
      tick();
      check("to_wen_a0",  32'(tx_write_en), 1);
      check("to_data_a0", tx_data_out, 32'hA000_0000);
      check("to_count3",  32'(fifo_count), 3);
      check("to_ready",   32'(push_ready), 1);
      tick();
      check("to_wen_off", 32'(tx_write_en), 0);
      repeat (3) tick();
      check("to_wen_pre", 32'(tx_write_en), 0);
      tick();
      check("to_wen_a1",  32'(tx_write_en), 1);
      check("to_data_a1", tx_data_out, 32'hA000_0001);
      collect(2, 20);
      check("to_data_a2", got_at(0), 32'hA000_0002);
      check("to_data_a3", got_at(1), 32'hA000_0003);
      check("to_dropped_gone", 32'(fifo_count), 0);

      // Busy transmitter model: ordered issue, none while busy.
      man_busy = 1'b1;
      push(32'h1); push(32'h2); push(32'h3);
      model_en = 1'b1;
      collect(3, 80);
      check("busy_w0", got_at(0), 32'h1);
      check("busy_w1", got_at(1), 32'h2);
      check("busy_w2", got_at(2), 32'h3);
      repeat (15) tick();
      check("busy_viol", 32'(busy_viol), 0);
      check("busy_count", 32'(fifo_count), 0);
      model_en = 1'b0;

      // Three fill/drain rounds exercise pointer wrap.
      for (int r = 0; r < 3; r++) begin
         man_busy = 1'b1;
         for (int i = 0; i < 4; i++) push(32'(r * 256 + i));
         check("wrap_full", 32'(fifo_count), 4);
         man_busy = 1'b0;
         collect(4, 40);
         for (int i = 0; i < 4; i++) check("wrap_data", got_at(i), 32'(r * 256 + i));
         check("wrap_count0", 32'(fifo_count), 0);
      end

      // Full blocks push on a pop edge; later push and pop on the same edge keep count.
      repeat (5) tick();
      man_busy = 1'b1;
      for (int i = 0; i < 4; i++) push(32'hF0 + 32'(i));
      man_busy = 1'b0;
      push_valid = 1'b1; push_data = 32'hEE;
      tick();
      push_valid = 1'b0;
      check("pp_block_count", 32'(fifo_count), 3);
      check("pp_block_wen",   32'(tx_write_en), 1);
      check("pp_block_data",  tx_data_out, 32'hF0);
      repeat (4) tick();
      push_valid = 1'b1; push_data = 32'h77;
      tick();
      push_valid = 1'b0;
      check("pp_same_count",  32'(fifo_count), 3);
      check("pp_same_wen",    32'(tx_write_en), 1);
      check("pp_same_data",   tx_data_out, 32'hF1);
      collect(3, 30);
      check("pp_d0", got_at(0), 32'hF2);
      check("pp_d1", got_at(1), 32'hF3);
      check("pp_d2", got_at(2), 32'h77);
`ifdef UART_TX_FEEDER_DROP_CNT_EN
      check("drop_two", 32'(drop_count), 2);
`endif

      // Reset while draining with two words queued.
      man_busy = 1'b1;
      push(32'hB0); push(32'hB1);
      check("mr_count2", 32'(fifo_count), 2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mr_count", 32'(fifo_count), 0);
      check("mr_empty", 32'(fifo_empty), 1);
      check("mr_ready", 32'(push_ready), 1);
      check("mr_wen",   32'(tx_write_en), 0);
      check("mr_data",  tx_data_out, 0);
`ifdef UART_TX_FEEDER_DROP_CNT_EN
      check("mr_drop",  32'(drop_count), 0);
`endif
      man_busy = 1'b0;
      push(32'hC0);
      check("mr_idle_count", 32'(fifo_count), 1);
      tick();
      check("mr_idle_wen",  32'(tx_write_en), 1);
      check("mr_idle_data", tx_data_out, 32'hC0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
